// File: rtl/matrix_mode_ctrl.sv
// Mode control for the 16x16 LED matrix scanner: button debounce,
// direction/stop FSM and the slow animation clock.
//
// Ports:
//   clk       system clock, all logic on posedge
//   rst_n     synchronous reset, active-low
//   btn_left  raw left button, async, active-high
//   btn_right raw right button, async, active-high
//   btn_stop  raw stop button, async, active-high
//   clk_1hz   registered square wave at TICK_HZ, 50% duty
//   tick      one-cycle pulse in the cycle clk_1hz rises
//   stop      1 = show stop pattern
//   left      1 = left arrow, 0 = right arrow (direction to resume in STOP)
module matrix_mode_ctrl #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 1,
  parameter int DEB_CYC   = 1_000_000,
  parameter int STOP_HOLD = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_stop,
  output logic clk_1hz,
  output logic tick,
  output logic stop,
  output logic left
);

  localparam int HALF = CLK_HZ / (2 * TICK_HZ);
  localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int CW   = $clog2(DEB_CYC + 1);
  localparam int HOLD = (STOP_HOLD < 1) ? 1 : STOP_HOLD;
  localparam int HW   = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [DW-1:0] DIV_MAX  = DW'(HALF - 1);
  localparam logic [CW-1:0] DEB_MAX  = CW'(DEB_CYC - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD - 1);

  typedef enum logic [1:0] {
    RIGHT = 2'd0,
    LEFT  = 2'd1,
    STOP  = 2'd2
  } state_t;

  // Divider
  logic [DW-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      clk_1hz <= 1'b0;
      tick    <= 1'b0;
    end else if (div_cnt == DIV_MAX) begin
      div_cnt <= '0;
      clk_1hz <= ~clk_1hz;
      tick    <= ~clk_1hz;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      tick    <= 1'b0;
    end
  end

  // Input path: bit 0 right, bit 1 left, bit 2 stop
  logic [2:0]    raw;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    level;
  logic [2:0]    level_q;
  logic [2:0]    press;
  logic [CW-1:0] deb_cnt [3];

  assign raw = {btn_stop, btn_left, btn_right};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_q <= '0;
      press   <= '0;
      for (int i = 0; i < 3; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_q <= level;
      press   <= level & ~level_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == level[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_MAX) begin
          level[i]   <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Direction / stop FSM
  state_t        state;
  state_t        nxt;
  logic          prev_dir;
  logic          nxt_prev;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] nxt_hold;
  logic          p_right;
  logic          p_left;
  logic          p_stop;

  assign p_right = press[0];
  assign p_left  = press[1];
  assign p_stop  = press[2];

  // Presses are checked before the tick, so a press landing on the
  // expiring tick wins over the auto-return.
  always_comb begin
    nxt      = state;
    nxt_prev = prev_dir;
    nxt_hold = hold_cnt;
    unique case (state)
      RIGHT, LEFT: begin
        if (p_stop) begin
          nxt      = STOP;
          nxt_prev = (state == LEFT);
          nxt_hold = '0;
        end else if (p_left) begin
          nxt = LEFT;
        end else if (p_right) begin
          nxt = RIGHT;
        end
      end
      STOP: begin
        if (p_stop) begin
          nxt_hold = '0;
        end else if (p_left) begin
          nxt = LEFT;
        end else if (p_right) begin
          nxt = RIGHT;
        end else if (tick) begin
          if (hold_cnt == HOLD_MAX) begin
            nxt = prev_dir ? LEFT : RIGHT;
          end else begin
            nxt_hold = hold_cnt + 1'b1;
          end
        end
      end
      default: begin
        nxt = RIGHT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RIGHT;
      prev_dir <= 1'b0;
      hold_cnt <= '0;
      stop     <= 1'b0;
      left     <= 1'b0;
    end else begin
      state    <= nxt;
      prev_dir <= nxt_prev;
      hold_cnt <= nxt_hold;
      stop     <= (nxt == STOP);
      left     <= (nxt == LEFT) || ((nxt == STOP) && nxt_prev);
    end
  end

endmodule
